mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 clk  input  1  sole clock; all state updates on its rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-high; clears all state immediately, independent of clk.
REQ-003 stall  input  6  pipeline stall vector; 1 = Stop, 0 = NoStop; bit 3 = MEM input register, bit 4 = WB input register.
REQ-004 ex_to_mem_bus  input  145  from EX, MSB first: hi_we(1), lo_we(1), hi(32), lo(32), pc(32), mem_op(3), data_ram_en(1), data_ram_wen(4), sel_rf_res(1), rf_we(1), rf_waddr(5), ex_result(32).
REQ-005 data_sram_rdata  input  32  data SRAM read word; valid exactly one cycle after EX drove the request.
REQ-006 mem_to_wb_bus  output  136  to WB, MSB first: hi_we, lo_we, hi(32), lo(32), pc(32), rf_we, rf_waddr(5), rf_wdata(32).
REQ-007 mem_to_id_bus  output  104  forwarding to ID, MSB first: rf_we, rf_waddr(5), rf_wdata(32), hi_we, lo_we, hi(32), lo(32).

Function
REQ-010 Input register R (145 bits) SHALL update per edge: stall[3]=1 and stall[4]=0 -> load all-zero bubble; else stall[3]=0 -> load ex_to_mem_bus; else hold.
REQ-011 All outputs SHALL be derived combinationally from R and the read-data buffer; no further pipeline delay; hi, lo, hi_we, lo_we, pc, rf_we, rf_waddr pass through unchanged.
REQ-012 Load flag: ld = data_ram_en & (data_ram_wen == 0) from R.
REQ-013 Read-data buffer: rbuf(32) and rbuf_v(1). Any edge loading R (bubble or new) SHALL clear rbuf_v; an edge holding R with ld=1 and rbuf_v=0 SHALL capture data_sram_rdata into rbuf and set rbuf_v; otherwise both hold.
REQ-014 Effective read word rd = rbuf_v ? rbuf : data_sram_rdata; a load held any number of cycles SHALL keep the word sampled in its first MEM cycle.
REQ-015 Byte offset = ex_result[1:0], little-endian (offset 0 = bits 7:0, offset 2 = bits 23:16).
REQ-016 mem_op decode: 001 lb sign-extended byte; 010 lbu zero-extended byte; 011 lh sign-extended half at offset[1] (0 -> bits 15:0, 1 -> bits 31:16); 100 lhu zero-extended half; all other codes full word rd.
REQ-017 Halfword with offset[0]=1 SHALL use offset[1] only (no alignment exception raised by this block).
REQ-018 rf_wdata = sel_rf_res ? load result : ex_result.
REQ-019 Store or non-memory instruction (ld=0) SHALL never set rbuf_v; rbuf contents then irrelevant.
REQ-020 Bubble (R=0) SHALL produce rf_we=0, hi_we=0, lo_we=0 on both output buses.
REQ-021 Simultaneous rst and any stall value: rst wins.

Reset
REQ-030 rst=1 SHALL asynchronously force R=0, rbuf=0, rbuf_v=0; all output bus fields therefore read 0 during reset.
REQ-031 Reset mid-load SHALL discard buffered data; first instruction after deassert uses live data_sram_rdata.
REQ-032 After rst falls, first edge obeys REQ-010 normally.

Verification
REQ-040 lw, stall=0, ex_result=0x100, sel_rf_res=1, rdata=0xDEADBEEF next cycle -> rf_wdata=0xDEADBEEF, rf_we as sent, both buses agree.
REQ-041 lb offset 3, rdata=0x80FF_0000 -> rf_wdata=0xFFFFFF80; lbu same -> 0x00000080; lh offset 2 -> 0xFFFF80FF; lhu offset 2 -> 0x000080FF.
REQ-042 lw in MEM, stall[3]=stall[4]=1 for 3 cycles, rdata changes to 0x12345678 after first cycle (first value 0xCAFEF00D) -> rf_wdata stays 0xCAFEF00D throughout.
REQ-043 stall[3]=1, stall[4]=0 -> next cycle R=0: rf_we=hi_we=lo_we=0, mem_to_wb_bus=0.
REQ-044 mult result passthrough hi_we=lo_we=1, hi=0x1, lo=0xFFFFFFFE, sel_rf_res=0 -> mem_to_wb_bus and mem_to_id_bus carry identical hi/lo and rf_wdata=ex_result.
REQ-045 Assert rst between clock edges during held load -> outputs zero immediately; after release, new lw returns live rdata, not stale rbuf.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage.
// Registers the EX->MEM bundle, buffers the data SRAM read word across
// stalls, extracts/extends load data and builds the WB and ID-forwarding
// buses combinationally from the stage register.
module mem_stage (
    input  logic         clk,
    input  logic         rst,
    input  logic [5:0]   stall,
    input  logic [144:0] ex_to_mem_bus,
    input  logic [31:0]  data_sram_rdata,
    output logic [135:0] mem_to_wb_bus,
    output logic [103:0] mem_to_id_bus
);

    // Field layout of the EX->MEM bundle; first member lands in the MSBs.
    typedef struct packed {
        logic        hi_we;
        logic        lo_we;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] pc;
        logic [2:0]  mem_op;
        logic        data_ram_en;
        logic [3:0]  data_ram_wen;
        logic        sel_rf_res;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] ex_result;
    } ex_mem_t;

    // Load sub-operation encodings; every other code reads a full word.
    localparam logic [2:0] OP_LB  = 3'b001;
    localparam logic [2:0] OP_LBU = 3'b010;
    localparam logic [2:0] OP_LH  = 3'b011;
    localparam logic [2:0] OP_LHU = 3'b100;

    ex_mem_t     r;
    logic [31:0] rbuf;
    logic        rbuf_v;

    logic        load_new;
    logic        load_bubble;
    logic        ld;
    logic [31:0] rd;
    logic [1:0]  offset;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_result;
    logic [31:0] rf_wdata;

    // Only the MEM (bit 3) and WB (bit 4) stall controls matter here.
    logic unused_stall;
    assign unused_stall = ^{stall[5], stall[2:0]};

    // A bubble is inserted when MEM stalls but WB keeps draining; a new
    // instruction enters whenever MEM is not stalled; otherwise R holds.
    assign load_bubble = stall[3] & ~stall[4];
    assign load_new    = ~stall[3];

    // Stage register: reset, bubble, load or hold.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r <= '0;
        end else if (load_bubble) begin
            r <= '0;
        end else if (load_new) begin
            r <= ex_to_mem_bus;
        end
    end

    assign ld = r.data_ram_en & (r.data_ram_wen == 4'b0000);

    // Read-data buffer: the SRAM word is only valid in the load's first MEM
    // cycle, so capture it on the first held edge and keep it until R moves.
    // NOTE: rbuf is reset as well so no stale word survives a reset, even
    // though rbuf_v alone would gate its use.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rbuf   <= '0;
            rbuf_v <= 1'b0;
        end else if (load_bubble || load_new) begin
            rbuf_v <= 1'b0;
        end else if (ld && !rbuf_v) begin
            rbuf   <= data_sram_rdata;
            rbuf_v <= 1'b1;
        end
    end

    assign rd     = rbuf_v ? rbuf : data_sram_rdata;
    assign offset = r.ex_result[1:0];

    // Little-endian byte and halfword lanes; halfwords ignore offset[0].
    always_comb begin
        rd_byte = rd[7:0];
        unique case (offset)
            2'd0: rd_byte = rd[7:0];
            2'd1: rd_byte = rd[15:8];
            2'd2: rd_byte = rd[23:16];
            2'd3: rd_byte = rd[31:24];
        endcase
        rd_half = offset[1] ? rd[31:16] : rd[15:0];
    end

    // Load-data extension by mem_op.
    // NOTE: the default assignment first keeps this block free of latches
    // for codes the case does not list.
    always_comb begin
        load_result = rd;
        case (r.mem_op)
            OP_LB:   load_result = {{24{rd_byte[7]}}, rd_byte};
            OP_LBU:  load_result = {24'd0, rd_byte};
            OP_LH:   load_result = {{16{rd_half[15]}}, rd_half};
            OP_LHU:  load_result = {16'd0, rd_half};
            default: load_result = rd;
        endcase
    end

    assign rf_wdata = r.sel_rf_res ? load_result : r.ex_result;

    assign mem_to_wb_bus = {r.hi_we, r.lo_we, r.hi, r.lo, r.pc,
                            r.rf_we, r.rf_waddr, rf_wdata};

    assign mem_to_id_bus = {r.rf_we, r.rf_waddr, rf_wdata,
                            r.hi_we, r.lo_we, r.hi, r.lo};

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage with hand-computed expected values.
module tb_mem_stage;

    typedef struct packed {
        logic        hi_we;
        logic        lo_we;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] pc;
        logic [2:0]  mem_op;
        logic        data_ram_en;
        logic [3:0]  data_ram_wen;
        logic        sel_rf_res;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] ex_result;
    } inst_t;

    logic         clk;
    logic         rst;
    logic [5:0]   stall;
    logic [144:0] ex_to_mem_bus;
    logic [31:0]  data_sram_rdata;
    logic [135:0] mem_to_wb_bus;
    logic [103:0] mem_to_id_bus;

    int    vectors;
    int    miscompares;
    inst_t cur;

    localparam logic [5:0] ST_RUN    = 6'b000000;
    localparam logic [5:0] ST_HOLD   = 6'b011000;
    localparam logic [5:0] ST_BUBBLE = 6'b001000;

    mem_stage dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .ex_to_mem_bus   (ex_to_mem_bus),
        .data_sram_rdata (data_sram_rdata),
        .mem_to_wb_bus   (mem_to_wb_bus),
        .mem_to_id_bus   (mem_to_id_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [135:0] obs,
                         input logic [135:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Compare both buses against the instruction in MEM plus expected wdata.
    task automatic check_out(input string tag, input logic [31:0] wdata);
        logic [135:0] ewb;
        logic [103:0] eid;
        ewb = {cur.hi_we, cur.lo_we, cur.hi, cur.lo, cur.pc,
               cur.rf_we, cur.rf_waddr, wdata};
        eid = {cur.rf_we, cur.rf_waddr, wdata,
               cur.hi_we, cur.lo_we, cur.hi, cur.lo};
        check({tag, "/wb"}, mem_to_wb_bus, ewb);
        check({tag, "/id"}, {32'd0, mem_to_id_bus}, {32'd0, eid});
    endtask

    task automatic check_zero(input string tag);
        check({tag, "/wb"}, mem_to_wb_bus, 136'd0);
        check({tag, "/id"}, {32'd0, mem_to_id_bus}, 136'd0);
    endtask

    task automatic issue(input inst_t i);
        cur           = i;
        ex_to_mem_bus = i;
    endtask

    function automatic inst_t mk_load(input logic [2:0] op,
                                      input logic [31:0] addr,
                                      input logic [4:0] waddr,
                                      input logic [31:0] pc);
        inst_t i;
        i              = '0;
        i.mem_op       = op;
        i.data_ram_en  = 1'b1;
        i.data_ram_wen = 4'h0;
        i.sel_rf_res   = 1'b1;
        i.rf_we        = 1'b1;
        i.rf_waddr     = waddr;
        i.ex_result    = addr;
        i.pc           = pc;
        return i;
    endfunction

    initial begin
        inst_t st;
        inst_t mul;
        vectors         = 0;
        miscompares     = 0;
        rst             = 1'b1;
        stall           = ST_RUN;
        data_sram_rdata = 32'h0;
        issue(mk_load(3'b000, 32'h100, 5'd5, 32'h0000_0400));

        // Reset state, and reset overriding a pending load at an edge.
        #3;
        check_zero("reset");
        tick;
        check_zero("reset_hold");
        #2 rst = 1'b0;

        // Plain lw: data arrives the cycle the load is in MEM.
        tick;
        data_sram_rdata = 32'hDEAD_BEEF;
        #1 check_out("lw", 32'hDEAD_BEEF);

        // Byte/halfword extraction from rdata 0x80FF0000.
        issue(mk_load(3'b001, 32'h103, 5'd6, 32'h404));
        tick;
        data_sram_rdata = 32'h80FF_0000;
        #1 check_out("lb_off3", 32'hFFFF_FF80);
        issue(mk_load(3'b010, 32'h103, 5'd7, 32'h408));
        tick;
        #1 check_out("lbu_off3", 32'h0000_0080);
        issue(mk_load(3'b011, 32'h102, 5'd8, 32'h40C));
        tick;
        #1 check_out("lh_off2", 32'hFFFF_80FF);
        issue(mk_load(3'b100, 32'h102, 5'd9, 32'h410));
        tick;
        #1 check_out("lhu_off2", 32'h0000_80FF);
        issue(mk_load(3'b011, 32'h103, 5'd10, 32'h414));
        tick;
        #1 check_out("lh_off3", 32'hFFFF_80FF);
        issue(mk_load(3'b001, 32'h102, 5'd11, 32'h418));
        tick;
        #1 check_out("lb_off2", 32'hFFFF_FFFF);

        // Load held three cycles keeps its first-cycle word.
        issue(mk_load(3'b000, 32'h140, 5'd12, 32'h41C));
        tick;
        data_sram_rdata = 32'hCAFE_F00D;
        #1 check_out("hold_c0", 32'hCAFE_F00D);
        stall = ST_HOLD;
        tick;
        data_sram_rdata = 32'h1234_5678;
        #1 check_out("hold_c1", 32'hCAFE_F00D);
        tick;
        #1 check_out("hold_c2", 32'hCAFE_F00D);
        tick;
        #1 check_out("hold_c3", 32'hCAFE_F00D);
        stall = ST_RUN;

        // Held store never buffers: read word stays live.
        st              = '0;
        st.data_ram_en  = 1'b1;
        st.data_ram_wen = 4'hF;
        st.sel_rf_res   = 1'b1;
        st.ex_result    = 32'h300;
        st.pc           = 32'h420;
        issue(st);
        tick;
        data_sram_rdata = 32'hAAAA_0001;
        #1 check_out("store_c0", 32'hAAAA_0001);
        stall = ST_HOLD;
        tick;
        data_sram_rdata = 32'hBBBB_0002;
        #1 check_out("store_c1", 32'hBBBB_0002);
        stall = ST_RUN;

        // Bubble: MEM stalled, WB not.
        stall = ST_BUBBLE;
        tick;
        #1 check_zero("bubble");
        stall = ST_RUN;

        // hi/lo passthrough with ALU result selected.
        mul            = '0;
        mul.hi_we      = 1'b1;
        mul.lo_we      = 1'b1;
        mul.hi         = 32'h0000_0001;
        mul.lo         = 32'hFFFF_FFFE;
        mul.pc         = 32'h424;
        mul.ex_result  = 32'h5555_AAAA;
        mul.rf_waddr   = 5'd3;
        issue(mul);
        tick;
        data_sram_rdata = 32'h9999_9999;
        #1 check_out("mult", 32'h5555_AAAA);

        // Asynchronous reset during a held load, then a fresh load.
        issue(mk_load(3'b000, 32'h180, 5'd13, 32'h428));
        tick;
        data_sram_rdata = 32'h1111_2222;
        #1 check_out("rst_ld_c0", 32'h1111_2222);
        stall = ST_HOLD;
        tick;
        data_sram_rdata = 32'h3333_4444;
        #1 check_out("rst_ld_c1", 32'h1111_2222);
        #2 rst = 1'b1;
        #1 check_zero("rst_mid");
        #1 rst = 1'b0;
        stall = ST_RUN;
        issue(mk_load(3'b000, 32'h200, 5'd14, 32'h42C));
        tick;
        data_sram_rdata = 32'h5555_6666;
        #1 check_out("post_rst_lw", 32'h5555_6666);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
